// File: rtl/timer_dev.sv
// timer_dev: programmable down-counter peripheral on the CPU device bus.
//
// Ports
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset
//   addr    : word select (CPU byte address bits [3:2])
//   we      : write strobe, sampled at rising clk
//   dev_wd  : write data from CPU
//   dev_rd  : read data to CPU, combinational from addr
//   irq     : interrupt request to CP0 HWInt
//
// Register map
//   00 CTRL   : bit0 EN, bits2:1 MODE (01 = auto-reload), bit3 IM
//   01 PRESET : reload value
//   10 COUNT  : current count, read-only
//   11 reserved, reads 0
//
// state | meaning
// IDLE  | count holds, waiting for EN
// LOAD  | COUNT <= PRESET, prescaler cleared
// CNT   | COUNT decrements on each prescaler tick
// INT   | one-cycle expiry state, reload or stop depending on MODE

module timer_dev #(
  parameter int unsigned DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] dev_wd,
  output logic [31:0] dev_rd,
  output logic        irq
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  localparam logic [1:0] MODE_AUTO = 2'b01;

  logic [1:0]    state_q, state_d;
  logic          en_q, en_d;
  logic [1:0]    mode_q, mode_d;
  logic          im_q, im_d;
  logic [31:0]   preset_q, preset_d;
  logic [31:0]   count_q, count_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          pend_q, pend_d;

  logic wr_ctrl, wr_pre, en_eff, tick;

  assign wr_ctrl = we && (addr == 2'b00);
  assign wr_pre  = we && (addr == 2'b01);
  // EN as it will be after this edge, so an enabling write moves the FSM
  // on the same edge and a disabling write freezes COUNT on that edge.
  assign en_eff  = wr_ctrl ? dev_wd[0] : en_q;
  assign tick    = (pre_q == PRE_LAST);

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;
    pre_d    = pre_q;
    pend_d   = pend_q;

    if (wr_ctrl) begin
      en_d   = dev_wd[0];
      mode_d = dev_wd[2:1];
      im_d   = dev_wd[3];
    end
    if (wr_pre) begin
      preset_d = dev_wd;
    end
    if (wr_ctrl || wr_pre) begin
      pend_d = 1'b0;
    end

    // Expiry below is evaluated after the CPU write so it overrides it:
    // pending set wins over clear, and EN is forced low.
    case (state_q)
      ST_IDLE: begin
        if (en_eff) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        pre_d   = '0;
        state_d = en_eff ? ST_CNT : ST_IDLE;
      end
      ST_CNT: begin
        if (!en_eff) begin
          state_d = ST_IDLE;
        end else begin
          pre_d = tick ? '0 : pre_q + PW'(1);
          if (tick) begin
            if (count_q > 32'd1) begin
              count_d = count_q - 32'd1;
            end else begin
              count_d = 32'd0;
              state_d = ST_INT;
              if (mode_q != MODE_AUTO) begin
                en_d   = 1'b0;
                pend_d = 1'b1;
              end
            end
          end
        end
      end
      default: begin
        state_d = (mode_q == MODE_AUTO) ? ST_LOAD : ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'b00;
      im_q     <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      pre_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pre_q    <= pre_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    dev_rd = 32'd0;
    case (addr)
      2'b00:   dev_rd = {28'd0, im_q, mode_q, en_q};
      2'b01:   dev_rd = preset_q;
      2'b10:   dev_rd = count_q;
      default: dev_rd = 32'd0;
    endcase
  end

  // Built from registers only; auto-reload pulses in INT, one-shot is a level.
  assign irq = (mode_q == MODE_AUTO) ? (im_q && (state_q == ST_INT))
                                     : (im_q && pend_q);

endmodule

// File: tb/tb_timer_dev.sv
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  addr = 2'd2;
  logic        we = 1'b0;
  logic [31:0] dev_wd = 32'd0;
  logic [31:0] rd1, rd4;
  logic        irq1, irq4;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    bit          d4;
    logic [31:0] cnt;
    logic        irq;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  timer_dev #(.DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .addr(addr), .we(we),
    .dev_wd(dev_wd), .dev_rd(rd1), .irq(irq1)
  );

  timer_dev #(.DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .addr(addr), .we(we),
    .dev_wd(dev_wd), .dev_rd(rd4), .irq(irq4)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input string t, input bit d4, input logic [31:0] c, input logic i);
    exp_t e;
    e.tag = t;
    e.d4  = d4;
    e.cnt = c;
    e.irq = i;
    sb.push_back(e);
  endtask

  // One clock edge; afterwards COUNT (addr 10) and irq are compared with the
  // next expected entry, if any.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    we = 1'b0;
    addr = 2'd2;
    dev_wd = 32'd0;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.d4) begin
        check_val({e.tag, "_cnt"}, rd4, e.cnt);
        check_val({e.tag, "_irq"}, {31'd0, irq4}, {31'd0, e.irq});
      end else begin
        check_val({e.tag, "_cnt"}, rd1, e.cnt);
        check_val({e.tag, "_irq"}, {31'd0, irq1}, {31'd0, e.irq});
      end
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    we = 1'b1;
    dev_wd = d;
    step();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd1;
    addr = 2'd2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    we = 1'b0;
    addr = 2'd2;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] v;

    // reset values
    #2;
    check_val("rst_irq", {31'd0, irq1}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      check_val("rst_rd", v, 32'd0);
    end
    do_reset();

    // one-shot, PRESET=5
    wr(2'd1, 32'd5);
    push("os_n", 0, 32'd0, 1'b0);
    for (int k = 5; k >= 1; k--) push("os_cnt", 0, 32'(k), 1'b0);
    push("os_exp", 0, 32'd0, 1'b1);
    push("os_hold", 0, 32'd0, 1'b1);
    wr(2'd0, 32'h9);
    repeat (7) step();
    rd(2'd0, v);
    check_val("os_ctrl", v, 32'h8);
    push("os_clr", 0, 32'd0, 1'b0);
    wr(2'd1, 32'd7);
    rd(2'd1, v);
    check_val("os_preset", v, 32'd7);

    // auto-reload, PRESET=3, IM=1
    do_reset();
    wr(2'd1, 32'd3);
    push("ar_n", 0, 32'd0, 1'b0);
    for (int p = 0; p < 4; p++) begin
      push("ar_c3", 0, 32'd3, 1'b0);
      push("ar_c2", 0, 32'd2, 1'b0);
      push("ar_c1", 0, 32'd1, 1'b0);
      push("ar_int", 0, 32'd0, 1'b1);
      push("ar_ld", 0, 32'd0, 1'b0);
    end
    wr(2'd0, 32'hB);
    repeat (20) step();

    // auto-reload, IM=0
    do_reset();
    wr(2'd1, 32'd3);
    push("am_n", 0, 32'd0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      push("am_c3", 0, 32'd3, 1'b0);
      push("am_c2", 0, 32'd2, 1'b0);
      push("am_c1", 0, 32'd1, 1'b0);
      push("am_int", 0, 32'd0, 1'b0);
      push("am_ld", 0, 32'd0, 1'b0);
    end
    wr(2'd0, 32'h3);
    repeat (10) step();

    // pause and restart
    do_reset();
    wr(2'd1, 32'd10);
    push("pz_n", 0, 32'd0, 1'b0);
    for (int k = 10; k >= 6; k--) push("pz_cnt", 0, 32'(k), 1'b0);
    wr(2'd0, 32'h9);
    repeat (5) step();
    repeat (21) push("pz_hold", 0, 32'd6, 1'b0);
    wr(2'd0, 32'h8);
    repeat (20) step();
    push("pz_re", 0, 32'd6, 1'b0);
    push("pz_load", 0, 32'd10, 1'b0);
    push("pz_run", 0, 32'd9, 1'b0);
    wr(2'd0, 32'h9);
    repeat (2) step();

    // PRESET=0 expires on first tick
    do_reset();
    push("p0_n", 0, 32'd0, 1'b0);
    push("p0_ld", 0, 32'd0, 1'b0);
    push("p0_irq", 0, 32'd0, 1'b1);
    wr(2'd0, 32'h9);
    repeat (2) step();

    // ignored writes and reserved address
    do_reset();
    push("wcnt", 0, 32'd0, 1'b0);
    wr(2'd2, 32'h55);
    push("wres", 0, 32'd0, 1'b0);
    wr(2'd3, 32'h55);
    rd(2'd3, v);
    check_val("res_rd", v, 32'd0);
    push("wctl", 0, 32'd0, 1'b0);
    wr(2'd0, 32'hFFFF_FFF6);
    rd(2'd0, v);
    check_val("ctrl_mask", v, 32'h6);
    push("wpre", 0, 32'd0, 1'b0);
    wr(2'd1, 32'hDEAD_BEEF);
    rd(2'd1, v);
    check_val("pre_rd", v, 32'hDEAD_BEEF);

    // CTRL write coinciding with expiry
    do_reset();
    wr(2'd1, 32'd2);
    push("co_n", 0, 32'd0, 1'b0);
    push("co_c2", 0, 32'd2, 1'b0);
    push("co_c1", 0, 32'd1, 1'b0);
    wr(2'd0, 32'h9);
    repeat (2) step();
    push("co_exp", 0, 32'd0, 1'b1);
    push("co_hold", 0, 32'd0, 1'b1);
    wr(2'd0, 32'h9);
    step();
    rd(2'd0, v);
    check_val("co_ctrl", v, 32'h8);

    // prescaler, DIV=4
    do_reset();
    wr(2'd1, 32'd2);
    push("ps_n", 1, 32'd0, 1'b0);
    repeat (4) push("ps_c2", 1, 32'd2, 1'b0);
    repeat (4) push("ps_c1", 1, 32'd1, 1'b0);
    push("ps_exp", 1, 32'd0, 1'b1);
    push("ps_hold", 1, 32'd0, 1'b1);
    wr(2'd0, 32'h9);
    repeat (10) step();

    // reset asserted while irq is high
    do_reset();
    wr(2'd1, 32'd1);
    push("mr_n", 0, 32'd0, 1'b0);
    push("mr_ld", 0, 32'd1, 1'b0);
    push("mr_exp", 0, 32'd0, 1'b1);
    push("mr_hold", 0, 32'd0, 1'b1);
    wr(2'd0, 32'h9);
    repeat (3) step();
    rst = 1'b0;
    #1;
    check_val("mr_irq", {31'd0, irq1}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      check_val("mr_rd", v, 32'd0);
    end
    rst = 1'b1;
    repeat (3) push("mr_idle", 0, 32'd0, 1'b0);
    repeat (3) step();
    rd(2'd0, v);
    check_val("mr_ctrl", v, 32'd0);

    check_val("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
